// File: rtl/mem_log.sv
// Capture logger: records 2^(BRAM_ADDR_WIDTH+1) filter samples into a block RAM,
// two samples per word, then holds them for host readback through a
// registered read port that is active in every state.
module mem_log #(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int BRAM_DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         i_rst,
    input  logic [BRAM_DATA_WIDTH-1:0]   i_filter_data,
    input  logic                         i_run_log,
    input  logic                         i_read_log,
    input  logic [BRAM_ADDR_WIDTH-1:0]   i_addr_log_to_mem,
    output logic                         o_mem_full,
    output logic [2*BRAM_DATA_WIDTH-1:0] o_data_log_from_mem
);

    localparam int DEPTH  = 2 ** BRAM_ADDR_WIDTH;
    localparam int WORD_W = 2 * BRAM_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2,
        READ = 2'd3
    } state_e;

    state_e                       state;
    state_e                       state_next;
    logic [BRAM_ADDR_WIDTH-1:0]   wr_ptr;
    logic                         half;
    logic [BRAM_DATA_WIDTH-1:0]   low_half;
    logic                         full_q;
    logic                         start;
    logic                         wr_en;
    logic                         last_word;

    logic [WORD_W-1:0]            ram [DEPTH];

    // The final word of a capture lands at the all-ones address.
    assign last_word  = (wr_ptr == {BRAM_ADDR_WIDTH{1'b1}});
    assign o_mem_full = full_q;

    // State register.
    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the start/write strobes; run beats read everywhere.
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE, FULL, READ: begin
                if (i_run_log) begin
                    state_next = RUN;
                    start      = 1'b1;
                end else if (i_read_log && state != READ) begin
                    state_next = READ;
                end
            end
            RUN: begin
                if (half) begin
                    wr_en = 1'b1;
                    if (last_word) begin
                        state_next = FULL;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture datapath: pointer, half-word holding register and full flag.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            half     <= 1'b0;
            low_half <= '0;
            full_q   <= 1'b0;
        end else if (start) begin
            wr_ptr <= '0;
            half   <= 1'b0;
            full_q <= 1'b0;
        end else if (state == RUN) begin
            if (!half) begin
                low_half <= i_filter_data;
                half     <= 1'b1;
            end else begin
                half   <= 1'b0;
                wr_ptr <= wr_ptr + 1'b1;
                if (last_word) begin
                    full_q <= 1'b1;
                end
            end
        end
    end

    // RAM write port: later sample in the upper half.
    // NOTE: the RAM array has no reset so it maps onto block RAM; contents
    // survive reset and are simply overwritten by the next capture.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_ptr] <= {i_filter_data, low_half};
        end
    end

    // Registered read port, one cycle of latency in every state.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_data_log_from_mem <= '0;
        end else begin
            o_data_log_from_mem <= ram[i_addr_log_to_mem];
        end
    end

endmodule

// File: tb/tb_mem_log.sv
// Directed bench for mem_log using a reduced RAM depth so full captures stay short.
module tb_mem_log;

    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int DEPTH = 2 ** AW;
    localparam int NS    = 2 * DEPTH;

    logic            clk;
    logic            i_rst;
    logic [DW-1:0]   i_filter_data;
    logic            i_run_log;
    logic            i_read_log;
    logic [AW-1:0]   i_addr_log_to_mem;
    logic            o_mem_full;
    logic [2*DW-1:0] o_data_log_from_mem;

    logic [2*DW-1:0] model [DEPTH];
    logic [2*DW-1:0] fresh [3];

    int total;
    int bad;

    mem_log #(
        .BRAM_ADDR_WIDTH(AW),
        .BRAM_DATA_WIDTH(DW)
    ) dut (
        .clk                 (clk),
        .i_rst               (i_rst),
        .i_filter_data       (i_filter_data),
        .i_run_log           (i_run_log),
        .i_read_log          (i_read_log),
        .i_addr_log_to_mem   (i_addr_log_to_mem),
        .o_mem_full          (o_mem_full),
        .o_data_log_from_mem (o_data_log_from_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse run, then stream the model as lo/hi sample pairs, checking the full flag timing.
    task automatic do_capture();
        i_run_log = 1'b1;
        tick();
        i_run_log = 1'b0;
        check("run_clears_full", {31'd0, o_mem_full}, 32'd0);
        for (int i = 0; i < NS; i++) begin
            i_filter_data = i[0] ? model[i/2][31:16] : model[i/2][15:0];
            tick();
            if (i == NS - 2) check("full_not_early", {31'd0, o_mem_full}, 32'd0);
        end
        check("full_after_last", {31'd0, o_mem_full}, 32'd1);
    endtask

    task automatic read_all(input string tag);
        for (int k = 0; k < DEPTH; k++) begin
            i_read_log        = (k == 0);
            i_addr_log_to_mem = AW'(k);
            tick();
            check(tag, o_data_log_from_mem, model[k]);
        end
        i_read_log = 1'b0;
    endtask

    initial begin
        total             = 0;
        bad               = 0;
        i_rst             = 1'b1;
        i_run_log         = 1'b0;
        i_read_log        = 1'b0;
        i_filter_data     = '0;
        i_addr_log_to_mem = '0;

        // Reset held for two edges.
        tick();
        tick();
        check("rst_full", {31'd0, o_mem_full}, 32'd0);
        check("rst_data", o_data_log_from_mem, 32'd0);
        i_rst = 1'b0;
        tick();

        // Full capture of random words.
        for (int k = 0; k < DEPTH; k++) model[k] = $urandom;
        do_capture();

        // Samples arriving while FULL must not be written.
        for (int i = 0; i < 8; i++) begin
            i_filter_data = DW'($urandom);
            tick();
        end
        check("full_holds", {31'd0, o_mem_full}, 32'd1);

        // Readback entered with read_log plus address 0.
        read_all("readback");
        check("full_in_read", {31'd0, o_mem_full}, 32'd1);

        // Restart from READ with a known packing pattern at the front.
        model[0] = 32'h2222_1111;
        model[1] = 32'h4444_3333;
        for (int k = 2; k < DEPTH; k++) model[k] = $urandom;
        do_capture();

        // Read port works in FULL without a read command.
        i_addr_log_to_mem = '0;
        tick();
        check("pack_word0", o_data_log_from_mem, 32'h2222_1111);
        i_addr_log_to_mem = AW'(1);
        tick();
        check("pack_word1", o_data_log_from_mem, 32'h4444_3333);
        read_all("readback2");

        // Get back to FULL via a capture of the same data, then test priority.
        do_capture();
        i_run_log  = 1'b1;
        i_read_log = 1'b1;
        tick();
        i_run_log  = 1'b0;
        i_read_log = 1'b0;
        check("prio_run_full", {31'd0, o_mem_full}, 32'd0);

        // Three fresh words, then reset mid-run.
        fresh[0] = 32'hA5A5_0F0F;
        fresh[1] = 32'h1234_5678;
        fresh[2] = 32'hDEAD_BEEF;
        for (int i = 0; i < 6; i++) begin
            i_filter_data = i[0] ? fresh[i/2][31:16] : fresh[i/2][15:0];
            tick();
        end
        check("midrun_full", {31'd0, o_mem_full}, 32'd0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("midrun_rst_full", {31'd0, o_mem_full}, 32'd0);
        check("midrun_rst_data", o_data_log_from_mem, 32'd0);

        // Partial capture stays in RAM; untouched words keep the old capture.
        for (int k = 0; k < 4; k++) begin
            i_addr_log_to_mem = AW'(k);
            tick();
            check("partial", o_data_log_from_mem, (k < 3) ? fresh[k] : model[k]);
        end

        // Samples in IDLE must not write either.
        for (int i = 0; i < 4; i++) begin
            i_filter_data = 16'hFFFF;
            tick();
        end
        i_addr_log_to_mem = '0;
        tick();
        check("idle_no_write", o_data_log_from_mem, fresh[0]);
        check("idle_full", {31'd0, o_mem_full}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
